// File: rtl/rv_imm_pkg.sv
// Shared RV32I immediate-select and error-code definitions (also used by immgen).
package rv_imm_pkg;

  localparam int unsigned IMM_SEL_W = 3;
  typedef logic [IMM_SEL_W-1:0] imm_sel_t;

  localparam imm_sel_t IMM_I = 3'b000;
  localparam imm_sel_t IMM_S = 3'b001;
  localparam imm_sel_t IMM_B = 3'b010;
  localparam imm_sel_t IMM_U = 3'b011;
  localparam imm_sel_t IMM_J = 3'b100;

  typedef logic [1:0] imm_err_t;

  localparam imm_err_t ERR_OK       = 2'b00;
  localparam imm_err_t ERR_RANGE    = 2'b01;
  localparam imm_err_t ERR_MISALIGN = 2'b10;
  localparam imm_err_t ERR_SEL      = 2'b11;

  // True when imm[31:lsb] are all equal, i.e. the value survives truncation to lsb+1 bits.
  function automatic logic sign_fits(input logic [31:0] imm, input int unsigned lsb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << lsb;
    return ((imm & m) == m) || ((imm & m) == 32'h0);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters immediate bits into the instruction fields of a base word.
module imm_pack #(
  parameter int unsigned K = 3,
  parameter int unsigned N = 32
) (
  input  logic [K-1:0] sel_i,
  input  logic [N-1:0] imm_i,
  input  logic [N-1:0] base_i,
  output logic [N-1:0] instr_o
);
  import rv_imm_pkg::*;

  // Overwrite only the immediate field of the selected format; illegal sel passes base through.
  always_comb begin
    instr_o = base_i;
    case (sel_i)
      IMM_I: instr_o[31:20] = imm_i[11:0];
      IMM_S: begin
        instr_o[31:25] = imm_i[11:5];
        instr_o[11:7]  = imm_i[4:0];
      end
      IMM_B: begin
        instr_o[31]    = imm_i[12];
        instr_o[30:25] = imm_i[10:5];
        instr_o[11:8]  = imm_i[4:1];
        instr_o[7]     = imm_i[11];
      end
      IMM_U: instr_o[31:12] = imm_i[31:12];
      IMM_J: begin
        instr_o[31]    = imm_i[20];
        instr_o[30:21] = imm_i[10:1];
        instr_o[20]    = imm_i[11];
        instr_o[19:12] = imm_i[19:12];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: S1 checks representability, S2 packs the word.
module imm_encoder #(
  parameter int unsigned K     = 3,
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_sel,
  input  logic [N-1:0]     in_imm,
  input  logic [N-1:0]     in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_instr,
  output logic [1:0]       out_err,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  import rv_imm_pkg::*;

  logic             s1_v_q, s1_v_d;
  logic [K-1:0]     s1_sel_q, s1_sel_d;
  logic [N-1:0]     s1_imm_q, s1_imm_d;
  logic [N-1:0]     s1_base_q, s1_base_d;
  logic [1:0]       s1_err_q, s1_err_d;
  logic             s2_v_q, s2_v_d;
  logic [N-1:0]     s2_instr_q, s2_instr_d;
  logic [1:0]       s2_err_q, s2_err_d;
  logic [CNT_W-1:0] enc_q, enc_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic [1:0]   chk_err;
  logic [N-1:0] pack_instr;
  logic         s1_ready, s2_ready, out_fire;

  assign s2_ready  = !s2_v_q || out_ready;
  assign s1_ready  = !s1_v_q || s2_ready;
  // Gated by rst_n so nothing is offered an accept while reset is held.
  assign in_ready  = rst_n && s1_ready;
  assign out_fire  = s2_v_q && out_ready;

  assign out_valid = s2_v_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign enc_count = enc_q;
  assign err_count = err_q;

  // Representability checks on the incoming word; misalignment outranks range.
  always_comb begin
    chk_err = ERR_OK;
    case (in_sel)
      IMM_I, IMM_S: if (!sign_fits(in_imm, 11)) chk_err = ERR_RANGE;
      IMM_B: begin
        if (in_imm[0])                    chk_err = ERR_MISALIGN;
        else if (!sign_fits(in_imm, 12))  chk_err = ERR_RANGE;
      end
      IMM_J: begin
        if (in_imm[0])                    chk_err = ERR_MISALIGN;
        else if (!sign_fits(in_imm, 20))  chk_err = ERR_RANGE;
      end
      IMM_U: if (in_imm[11:0] != 12'h0) chk_err = ERR_RANGE;
      default: chk_err = ERR_SEL;
    endcase
  end

  imm_pack #(
    .K(K),
    .N(N)
  ) u_pack (
    .sel_i  (s1_sel_q),
    .imm_i  (s1_imm_q),
    .base_i (s1_base_q),
    .instr_o(pack_instr)
  );

  // Pipeline advance and saturating counters; clear beats a same-cycle increment.
  always_comb begin
    s1_v_d     = s1_v_q;
    s1_sel_d   = s1_sel_q;
    s1_imm_d   = s1_imm_q;
    s1_base_d  = s1_base_q;
    s1_err_d   = s1_err_q;
    s2_v_d     = s2_v_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    enc_d      = enc_q;
    err_d      = err_q;

    if (s1_ready) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_sel_d  = in_sel;
        s1_imm_d  = in_imm;
        s1_base_d = in_base;
        s1_err_d  = chk_err;
      end
    end

    if (s2_ready) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_instr_d = pack_instr;
        s2_err_d   = s1_err_q;
      end
    end

    if (clr_counts) begin
      enc_d = '0;
      err_d = '0;
    end else if (out_fire) begin
      if (enc_q != '1) enc_d = enc_q + CNT_W'(1);
      if (s2_err_q != ERR_OK && err_q != '1) err_d = err_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_sel_q   <= '0;
      s1_imm_q   <= '0;
      s1_base_q  <= '0;
      s1_err_q   <= '0;
      s2_v_q     <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= '0;
      enc_q      <= '0;
      err_q      <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_sel_q   <= s1_sel_d;
      s1_imm_q   <= s1_imm_d;
      s1_base_q  <= s1_base_d;
      s1_err_q   <= s1_err_d;
      s2_v_q     <= s2_v_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      enc_q      <= enc_d;
      err_q      <= err_d;
    end
  end

endmodule
